// File: rtl/rect_writer_pkg.sv
// rect_writer_pkg: shared types and default parameters for rect_writer.
//   state_t  - top-level sequencing states
//   mode_t   - pixel fill mode (solid / checkerboard)
//   DEF_*    - default parameter values
package rect_writer_pkg;

  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_COORD_W   = 11;
  localparam int DEF_HDR_BYTES = 4;

  typedef enum logic [2:0] {IDLE, HDR, ROW, PIX, DONE} state_t;
  typedef enum logic       {MODE_SOLID, MODE_CHECKER}  mode_t;

endpackage

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: rectangle walker for rect_writer.
// Holds the latched geometry, the x/y counters, the incremental row base and
// the pixel address adder.
//   load      - latch org/stride/bounds (operation start)
//   row_step  - one ROW cycle: set up the next row base, reset x
//   pix_step  - a pixel write was accepted: advance x
//   addr      - org + y*stride + x (mod 2^ADDR_W)
//   x_lsb/y_lsb, empty, last_pix, last_row - status for the top-level FSM
module raster_addr_gen #(
  parameter int ADDR_W  = 24,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               row_step,
  input  logic               pix_step,
  input  logic [ADDR_W-1:0]  org,
  input  logic [ADDR_W-1:0]  stride,
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] ymax,
  output logic [ADDR_W-1:0]  addr,
  output logic               x_lsb,
  output logic               y_lsb,
  output logic               empty,
  output logic               last_pix,
  output logic               last_row
);

  // One extra bit so x can step past 2^COORD_W-1 without wrapping.
  localparam int XW = COORD_W + 1;

  logic [ADDR_W-1:0] org_q, stride_q, row_base, ymin_off;
  logic [XW-1:0]     xmin_q, xmax_q, ymin_q, ymax_q, x, y;
  logic              first_row;

  // The only multiply: offset of the first row, used once per operation.
  assign ymin_off = ADDR_W'(ymin_q) * stride_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      org_q     <= '0;
      stride_q  <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      row_base  <= '0;
      x         <= '0;
      y         <= '0;
      first_row <= 1'b0;
    end else if (load) begin
      org_q     <= org;
      stride_q  <= stride;
      xmin_q    <= {1'b0, xmin};
      xmax_q    <= {1'b0, xmax};
      ymin_q    <= {1'b0, ymin};
      ymax_q    <= {1'b0, ymax};
      first_row <= 1'b1;
    end else if (row_step) begin
      first_row <= 1'b0;
      x         <= xmin_q;
      if (first_row) begin
        row_base <= org_q + ymin_off;
        y        <= ymin_q;
      end else begin
        row_base <= row_base + stride_q;
        y        <= y + 1'b1;
      end
    end else if (pix_step) begin
      x <= x + 1'b1;
    end
  end

  assign addr     = row_base + ADDR_W'(x);
  assign x_lsb    = x[0];
  assign y_lsb    = y[0];
  assign empty    = (xmin_q > xmax_q) || (ymin_q > ymax_q);
  assign last_pix = (x == xmax_q);
  assign last_row = (y == ymax_q);

endmodule

// File: rtl/rect_writer.sv
// rect_writer: header + rectangle raster writer for a byte-addressed
// framebuffer.
//   start/done         - operation handshake (start taken in IDLE or DONE)
//   base_addr, stride  - header address and framebuffer line pitch
//   xMin..yMax         - inclusive rectangle bounds
//   hdr_en, hdr_word   - optional little-endian header written at base_addr
//   mode, fill_data    - solid or checkerboard pixel data
//   waitrequest        - memory stall; outputs hold while high
//   addr/wren/wrdata   - memory write port
// Latency: start edge -> first header write next cycle; without header one
// ROW cycle precedes the first pixel. Every row (including the first) costs
// exactly one ROW cycle: the yMin*stride product is combinational and is
// folded into the row base during that single ROW cycle.
module rect_writer
  import rect_writer_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int HDR_BYTES = DEF_HDR_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   done,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      stride,
  input  logic [COORD_W-1:0]     xMin,
  input  logic [COORD_W-1:0]     xMax,
  input  logic [COORD_W-1:0]     yMin,
  input  logic [COORD_W-1:0]     yMax,
  input  logic                   hdr_en,
  input  logic [8*HDR_BYTES-1:0] hdr_word,
  input  logic                   mode,
  input  logic [7:0]             fill_data,
  input  logic                   waitrequest,
  output logic [ADDR_W-1:0]      addr,
  output logic                   wren,
  output logic [7:0]             wrdata
);

  localparam int HB_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

  state_t                 state, nstate;
  logic [8*HDR_BYTES-1:0] hdr_sh;
  logic [ADDR_W-1:0]      hdr_addr, org, r_addr;
  logic [HB_W-1:0]        hdr_cnt;
  mode_t                  mode_q;
  logic [7:0]             fill_q;
  logic                   start_ok, hdr_acc, pix_acc, last_hdr;
  logic                   x_lsb, y_lsb, r_empty, last_pix, last_row;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign hdr_acc  = (state == HDR) && !waitrequest;
  assign pix_acc  = (state == PIX) && !waitrequest;
  assign last_hdr = (hdr_cnt == HB_W'(HDR_BYTES - 1));
  assign org      = base_addr + (hdr_en ? ADDR_W'(HDR_BYTES) : '0);

  raster_addr_gen #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) u_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .row_step (state == ROW),
    .pix_step (pix_acc),
    .org      (org),
    .stride   (stride),
    .xmin     (xMin),
    .xmax     (xMax),
    .ymin     (yMin),
    .ymax     (yMax),
    .addr     (r_addr),
    .x_lsb    (x_lsb),
    .y_lsb    (y_lsb),
    .empty    (r_empty),
    .last_pix (last_pix),
    .last_row (last_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hdr_sh   <= '0;
      hdr_addr <= '0;
      hdr_cnt  <= '0;
      mode_q   <= MODE_SOLID;
      fill_q   <= '0;
    end else begin
      state <= nstate;
      if (start_ok) begin
        hdr_sh   <= hdr_word;
        hdr_addr <= base_addr;
        hdr_cnt  <= '0;
        mode_q   <= mode_t'(mode);
        fill_q   <= fill_data;
      end else if (hdr_acc) begin
        // Header serializer: low byte always on the bus, shift on accept.
        hdr_sh   <= hdr_sh >> 8;
        hdr_addr <= hdr_addr + 1'b1;
        hdr_cnt  <= hdr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nstate = state;
    wren   = 1'b0;
    addr   = '0;
    wrdata = '0;
    done   = 1'b0;
    case (state)
      IDLE: if (start) nstate = hdr_en ? HDR : ROW;
      HDR: begin
        wren   = 1'b1;
        addr   = hdr_addr;
        wrdata = hdr_sh[7:0];
        if (hdr_acc && last_hdr) nstate = ROW;
      end
      ROW: nstate = r_empty ? DONE : PIX;
      PIX: begin
        wren   = 1'b1;
        addr   = r_addr;
        wrdata = (mode_q == MODE_CHECKER && (x_lsb ^ y_lsb)) ? ~fill_q : fill_q;
        if (pix_acc && last_pix) nstate = last_row ? DONE : ROW;
      end
      DONE: begin
        done = 1'b1;
        if (start) nstate = hdr_en ? HDR : ROW;
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rect_writer.sv
module tb_rect_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [23:0] base_addr = '0, stride = '0, addr;
  logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
  logic        hdr_en = 1'b0;
  logic [31:0] hdr_word = '0;
  logic        mode = 1'b0;
  logic [7:0]  fill_data = '0, wrdata;
  logic        waitrequest = 1'b0;
  logic        wren;

  int n_chk = 0, n_pass = 0;
  logic [23:0] wa[$];
  logic [7:0]  wd[$];
  int          idle, stall_n;
  logic        timed_out;

  rect_writer dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .base_addr(base_addr), .stride(stride),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .hdr_en(hdr_en), .hdr_word(hdr_word), .mode(mode), .fill_data(fill_data),
    .waitrequest(waitrequest), .addr(addr), .wren(wren), .wrdata(wrdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_cfg(input logic he, input logic [23:0] b, input logic [23:0] s,
                         input int x0, input int x1, input int y0, input int y1,
                         input logic m, input logic [7:0] f, input logic [31:0] hw);
    hdr_en = he; base_addr = b; stride = s;
    xMin = 11'(x0); xMax = 11'(x1); yMin = 11'(y0); yMax = 11'(y1);
    mode = m; fill_data = f; hdr_word = hw;
  endtask

  // Pulse start, then collect accepted writes until done (bounded).
  task automatic run(input bit do_stall, input bit busy_start);
    wa.delete(); wd.delete();
    idle = 0; stall_n = 0; timed_out = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        // Config changes after start must not matter.
        fill_data = 8'hC3; hdr_word = 32'h12345678; base_addr = 24'h0ABCDE;
        stride = 24'h7; mode = ~mode; hdr_en = ~hdr_en; xMax = '0;
      end
      start = busy_start && (c == 1);
      if (done) begin timed_out = 1'b0; break; end
      if (do_stall && wren && wa.size() == 1 && stall_n < 3) begin
        waitrequest = 1'b1;
        stall_n++;
        chk("stall_addr_hold", 32'(addr), 32'h1283);
        chk("stall_data_hold", 32'(wrdata), 32'h5A);
      end else begin
        waitrequest = 1'b0;
      end
      if (wren && !waitrequest) begin wa.push_back(addr); wd.push_back(wrdata); end
      if (!wren) idle++;
    end
    start = 1'b0;
    waitrequest = 1'b0;
    chk("done_seen", 32'(timed_out), 32'h0);
  endtask

  initial begin
    logic [23:0] exp_a[6];
    logic [7:0]  exp_hd[4];
    logic [7:0]  exp_cd[4];
    exp_a  = '{24'h1282, 24'h1283, 24'h1284, 24'h1502, 24'h1503, 24'h1504};
    exp_hd = '{8'hFF, 8'hEE, 8'hDE, 8'hCC};
    exp_cd = '{8'h0F, 8'hF0, 8'hF0, 8'h0F};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wrdata", 32'(wrdata), 0);
    rst = 1'b0;

    // Header only, empty rectangle
    set_cfg(1, 24'h100, 24'd640, 5, 4, 0, 0, 0, 8'h00, 32'hCCDE_EEFF);
    run(0, 0);
    chk("hdr_count", 32'(wa.size()), 4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk($sformatf("hdr_addr%0d", i), 32'(wa[i]), 32'(24'h100 + 24'(i)));
      chk($sformatf("hdr_data%0d", i), 32'(wd[i]), 32'(exp_hd[i]));
    end
    chk("hdr_idle", 32'(idle), 1);
    repeat (3) @(negedge clk);
    chk("done_sticky", 32'(done), 1);
    chk("done_no_wren", 32'(wren), 0);

    // Solid 3x2, no header
    set_cfg(0, 24'h1000, 24'd640, 2, 4, 1, 2, 0, 8'h5A, 32'h0);
    run(0, 0);
    chk("solid_count", 32'(wa.size()), 6);
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      chk($sformatf("solid_addr%0d", i), 32'(wa[i]), 32'(exp_a[i]));
      chk($sformatf("solid_data%0d", i), 32'(wd[i]), 32'h5A);
    end
    chk("solid_row_bubbles", 32'(idle), 2);

    // Checkerboard 2x2
    set_cfg(0, 24'h1000, 24'd640, 0, 1, 0, 1, 1, 8'h0F, 32'h0);
    run(0, 0);
    chk("chk_count", 32'(wa.size()), 4);
    for (int i = 0; i < 4 && i < wd.size(); i++)
      chk($sformatf("chk_data%0d", i), 32'(wd[i]), 32'(exp_cd[i]));
    if (wa.size() == 4) chk("chk_addr3", 32'(wa[3]), 32'h1281);

    // Stall on 2nd pixel
    set_cfg(0, 24'h1000, 24'd640, 2, 4, 1, 2, 0, 8'h5A, 32'h0);
    run(1, 0);
    chk("stall_cycles", 32'(stall_n), 3);
    chk("stall_count", 32'(wa.size()), 6);
    for (int i = 0; i < 6 && i < wa.size(); i++)
      chk($sformatf("stall_addr%0d", i), 32'(wa[i]), 32'(exp_a[i]));

    // Address wrap in header, start pulsed while busy
    set_cfg(1, 24'hFFFFFE, 24'd640, 5, 4, 0, 0, 0, 8'h00, 32'hCCDE_EEFF);
    run(0, 1);
    chk("wrap_count", 32'(wa.size()), 4);
    if (wa.size() == 4) begin
      chk("wrap_addr0", 32'(wa[0]), 32'hFFFFFE);
      chk("wrap_addr1", 32'(wa[1]), 32'hFFFFFF);
      chk("wrap_addr2", 32'(wa[2]), 32'h000000);
      chk("wrap_addr3", 32'(wa[3]), 32'h000001);
    end
    repeat (2) @(negedge clk);
    chk("busy_start_ignored", 32'(wren), 0);

    // Reset during PIX, then restart from the header
    set_cfg(1, 24'h100, 24'd640, 2, 4, 1, 2, 0, 8'h5A, 32'hCCDE_EEFF);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pix_before_rst_wren", 32'(wren), 1);
    chk("pix_before_rst_addr", 32'(addr), 32'h387);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wren", 32'(wren), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_addr", 32'(addr), 0);
    rst = 1'b0;
    set_cfg(1, 24'h100, 24'd640, 2, 4, 1, 2, 0, 8'h5A, 32'hCCDE_EEFF);
    run(0, 0);
    chk("restart_count", 32'(wa.size()), 10);
    if (wa.size() == 10) begin
      chk("restart_addr0", 32'(wa[0]), 32'h100);
      chk("restart_data0", 32'(wd[0]), 32'hFF);
      chk("restart_addr4", 32'(wa[4]), 32'h386);
      chk("restart_addr9", 32'(wa[9]), 32'h608);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rect_writer.md
# rect_writer

Parametrised successor to the single-rectangle header/raster writer. On `start`, it optionally emits a little-endian multi-byte header, then walks a rectangle `[xMin..xMax] × [yMin..yMax]` of a byte-addressed framebuffer with configurable base and line stride. Each pixel gets either a solid fill or a checkerboard pattern. It sits between the frame-setup control FSM and the memory write port, and honours a memory `waitrequest` stall.

## Interface
- `ADDR_W`, 24: address width; all address arithmetic wraps modulo 2^ADDR_W.
- `COORD_W`, 11: width of x/y coordinates.
- `HDR_BYTES`, 4: header length in bytes (≥1).
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin operation; sampled only in IDLE or DONE.
- `done` out 1: operation complete.
- `base_addr` in ADDR_W: first header byte address.
- `stride` in ADDR_W: bytes per framebuffer line.
- `xMin`, `xMax`, `yMin`, `yMax` in COORD_W each: inclusive rectangle bounds, unsigned.
- `hdr_en` in 1: emit the header before the raster.
- `hdr_word` in 8*HDR_BYTES: header value.
- `mode` in 1: 0 = solid, 1 = checkerboard.
- `fill_data` in 8: pixel value.
- `waitrequest` in 1: memory stall; the current write is not accepted while high.
- `addr` out ADDR_W: write address.
- `wren` out 1: write strobe.
- `wrdata` out 8: write data.

## Operation
- On `start`, latch all configuration inputs. Later input changes have no effect until the next `start`.
- **Header phase** (only if `hdr_en`):
  - HDR_BYTES writes.
  - Write k has `addr = base_addr + k` and `wrdata = hdr_word[8k+7:8k]`, LSB first.
  - Raster origin `org = base_addr + HDR_BYTES` if `hdr_en`, else `org = base_addr`.
- **Raster phase:**
  - Iteration order: for y from yMin to yMax (outer), x from xMin to xMax (inner).
  - `addr = org + y*stride + x`, with x and y zero-extended to ADDR_W.
  - Row base is computed incrementally by adding `stride` per row. No multiplier, except a single `yMin*stride` computed in the ROW setup cycle; this may be a shift-add over multiple cycles, but then ROW latency grows and must be documented in the RTL header.
- **Pixel data:**
  - mode 0: `fill_data`.
  - mode 1: `fill_data` if `(x[0]^y[0])==0`, else `~fill_data`.
- **Empty rectangle** (`xMin>xMax` or `yMin>yMax`): no raster writes; header still emitted if enabled.
- **States:**
  - IDLE → HDR on `start` with `hdr_en`.
  - IDLE → ROW on `start` without `hdr_en`.
  - HDR → ROW after the last header byte is accepted.
  - ROW → PIX if the rectangle is non-empty, else ROW → DONE.
  - PIX → ROW at end of each line unless y==yMax; PIX → DONE after the last pixel is accepted.
  - DONE → HDR/ROW on a new `start`.
- `start` while in HDR/ROW/PIX is ignored.

## Timing
- Reset values: `done=0`, `wren=0`, `addr=0`, `wrdata=0`, state IDLE. The values apply the cycle after `rst` is sampled high, including mid-operation.
- A write is accepted in a cycle with `wren && !waitrequest`.
- While `waitrequest` is high, `addr`/`wren`/`wrdata` hold stable.
- `start` is sampled at edge 0; the first `wren` is high in the cycle after edge 0 (HDR), or after one ROW cycle (no header).
- Pixels within a row stream back-to-back at one write per cycle when unstalled.
- Each row costs exactly one ROW cycle with `wren=0`.
- `done` rises the cycle after the final accepted write (or after ROW for an empty rectangle with no header). It stays high until the cycle after the next accepted `start`.
- Coordinate counters are COORD_W+1 bits internally, so `xMax = 2^COORD_W−1` terminates without wrap.

## Structure
- Package `rect_writer_pkg` holds:
  - state enum `{IDLE, HDR, ROW, PIX, DONE}`,
  - mode enum `{MODE_SOLID, MODE_CHECKER}`,
  - default parameter constants.
- Sub-module `raster_addr_gen` holds the row-base accumulator, x/y counters, last-pixel/last-row flags and the address adder. The top level owns the FSM, header serializer and data mux.

## Test plan
- Header only:
  - Stimulus: `hdr_en=1`, `hdr_word=32'hCCDE_EEFF`, `base=0x100`, empty rect (xMin=5, xMax=4).
  - Response: writes FF@0x100, EE@0x101, DE@0x102, CC@0x103; then `done`.
- Solid 3×2:
  - Stimulus: `hdr_en=0`, `base=0x1000`, `stride=640`, x 2..4, y 1..2, `fill=0x5A`.
  - Response: addresses 0x1282–0x1284, 0x1502–0x1504, data 0x5A; six writes, exactly two ROW bubbles.
- Checker:
  - Stimulus: `mode=1`, `fill=0x0F`, x 0..1, y 0..1.
  - Response: data 0F, F0, F0, 0F.
- Stall:
  - Stimulus: `waitrequest` high for 3 cycles on the 2nd pixel.
  - Response: `addr`/`wrdata` held constant during the stall; no duplicate or skipped writes; total write count unchanged.
- Reset mid-PIX:
  - Stimulus: assert `rst` for 1 cycle during PIX.
  - Response: `wren=0` and `done=0` next cycle; a new `start` restarts from the header.
- Address wrap and boundaries:
  - Stimulus: `base=0xFFFFFE`, `hdr_en=1`, `HDR_BYTES=4`.
  - Response: header addresses FFFFFE, FFFFFF, 000000, 000001.
  - Stimulus: `start` pulsed while busy.
  - Response: ignored.
